// File: rtl/el_scan_out.sv
// el_scan_out: frame-buffer reader and EL panel driver.
// Scans the shared frame RAM in raster order, reads one byte (4 pixels,
// two bit-planes) per active clock, and drives the 4-bit EL panel with
// line/frame strobes. Three grey levels come from frame-rate modulation:
// plane B is always shown, plane A only in frames with phase 0.
// Pipeline: stage 0 counters -> stage 1 RAM data -> stage 2 output flops.
`timescale 1ns/1ps

module el_scan_out #(
    parameter int H_BYTES  = 80,
    parameter int V_LINES  = 240,
    parameter int H_BLANK  = 8,
    parameter int H_SYNC_W = 4,
    parameter int V_BLANK  = 4
) (
    input  logic        pixClk,
    input  logic        nReset,
    input  logic        enable,
    output logic [14:0] rdAddr,
    output logic        rdEn,
    input  logic [7:0]  rdData,
    output logic [3:0]  elData,
    output logic        elDataEn,
    output logic        elHsync,
    output logic        elVsync,
    output logic        frameDone
);

    localparam int H_TOTAL = H_BYTES + H_BLANK;
    localparam int V_TOTAL = V_LINES + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT    = HW'(H_BYTES);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_BYTES + 2);
    localparam logic [HW-1:0] HS_END   = HW'(H_BYTES + 2 + H_SYNC_W);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [HW-1:0] H_ZERO   = HW'(0);
    localparam logic [VW-1:0] V_ACT    = VW'(V_LINES);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ONE    = VW'(1);
    localparam logic [VW-1:0] V_ZERO   = VW'(0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Grey mapping: high plane always lit, low plane only on phase-0 frames.
    function automatic logic [3:0] grey_level(input logic [7:0] data, input logic phase_zero);
        return data[7:4] | (data[3:0] & {4{phase_zero}});
    endfunction

    // Stage 0: scan position and control
    logic [0:0]    state_q,   state_d;
    logic [HW-1:0] h_cnt_q,   h_cnt_d;
    logic [VW-1:0] v_cnt_q,   v_cnt_d;
    logic [14:0]   addr_q,    addr_d;
    logic [1:0]    phase_q,   phase_d;
    logic          rd_en_q,   rd_en_d;
    logic [14:0]   rd_addr_q, rd_addr_d;

    // Stage 1: strobes travelling alongside the RAM access
    logic de1_q, de1_d;
    logic hs1_q, hs1_d;
    logic vs1_q, vs1_d;
    logic fd1_q, fd1_d;
    logic ph0_1_q, ph0_1_d;

    // Stage 2: panel outputs
    logic [3:0] el_data_q, el_data_d;
    logic       el_de_q,   el_de_d;
    logic       el_hs_q,   el_hs_d;
    logic       el_vs_q,   el_vs_d;
    logic       frame_done_q, frame_done_d;

    logic scan_s;
    logic active_s;
    logic last_pos_s;
    logic hsync0_s;
    logic vsync0_s;

    // Decode the current scan position into stage-0 qualifiers and strobes
    always_comb begin
        scan_s     = (state_q == ST_SCAN);
        active_s   = scan_s && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        last_pos_s = scan_s && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        hsync0_s   = scan_s && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vsync0_s   = scan_s && (v_cnt_q == V_ZERO);
    end

    // FSM, raster counters, running read address and frame phase
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = H_ZERO;
                v_cnt_d = V_ZERO;
                addr_d  = 15'd0;
                if (enable) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (last_pos_s) begin
                    // Frame boundary: rewind and decide whether to keep going
                    h_cnt_d = H_ZERO;
                    v_cnt_d = V_ZERO;
                    addr_d  = 15'd0;
                    if (phase_q == 2'd2) begin
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                    if (enable) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (h_cnt_q == H_LAST) begin
                        h_cnt_d = H_ZERO;
                        v_cnt_d = v_cnt_q + V_ONE;
                    end else begin
                        h_cnt_d = h_cnt_q + H_ONE;
                    end
                    // Address advances by one per read; no line*width multiply
                    if (active_s) begin
                        addr_d = addr_q + 15'd1;
                    end else begin
                        addr_d = addr_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = H_ZERO;
                v_cnt_d = V_ZERO;
                addr_d  = 15'd0;
                phase_d = 2'd0;
            end
        endcase

        // Read port is registered from the next position so rdEn/rdAddr
        // describe the same cycle as the counters (stage 0).
        rd_en_d = (state_d == ST_SCAN) && (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        if (rd_en_d) begin
            rd_addr_d = addr_d;
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // Two-stage delay of strobes plus grey mapping of the returned RAM byte
    always_comb begin
        de1_d   = rd_en_q;
        hs1_d   = hsync0_s;
        vs1_d   = vsync0_s;
        fd1_d   = last_pos_s;
        ph0_1_d = (phase_q == 2'd0);

        el_de_d      = de1_q;
        el_hs_d      = hs1_q;
        el_vs_d      = vs1_q;
        frame_done_d = fd1_q;
        if (de1_q) begin
            el_data_d = grey_level(rdData, ph0_1_q);
        end else begin
            el_data_d = 4'h0;
        end
    end

    // All state registers; reset clears counters, read port and pipeline
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= H_ZERO;
            v_cnt_q      <= V_ZERO;
            addr_q       <= 15'd0;
            phase_q      <= 2'd0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= 15'd0;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            fd1_q        <= 1'b0;
            ph0_1_q      <= 1'b0;
            el_data_q    <= 4'h0;
            el_de_q      <= 1'b0;
            el_hs_q      <= 1'b0;
            el_vs_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            de1_q        <= de1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            fd1_q        <= fd1_d;
            ph0_1_q      <= ph0_1_d;
            el_data_q    <= el_data_d;
            el_de_q      <= el_de_d;
            el_hs_q      <= el_hs_d;
            el_vs_q      <= el_vs_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rdAddr    = rd_addr_q;
    assign rdEn      = rd_en_q;
    assign elData    = el_data_q;
    assign elDataEn  = el_de_q;
    assign elHsync   = el_hs_q;
    assign elVsync   = el_vs_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_el_scan_out.sv
// Directed testbench for el_scan_out with default geometry (80x240 bytes,
// 88-clock lines, 21472-clock frames). A small RAM model answers reads one
// clock after rdEn. Expected values come from the frame position k (clocks
// since the first read of the frame) and the grey-mapping formula.
`timescale 1ns/1ps

module tb_el_scan_out;

    localparam int HB    = 80;
    localparam int VL    = 240;
    localparam int HT    = 88;
    localparam int FRAME = 21472;
    localparam int HSW   = 4;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fd;
        logic [14:0] addr;
    } s0_t;

    logic        pixClk = 1'b0;
    logic        nReset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  rdData = 8'h00;
    logic [14:0] rdAddr;
    logic        rdEn;
    logic [3:0]  elData;
    logic        elDataEn;
    logic        elHsync;
    logic        elVsync;
    logic        frameDone;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit const_mode = 1'b0;
    bit carry_fd   = 1'b0;

    // per-run tallies filled by observe()
    int t_en, t_addr, t_de, t_hs, t_vs, t_fd, t_data;
    int t_rd, t_hs_cnt, t_vs_cnt, t_fd_cnt;
    logic [14:0] t_last, t_first, t_line1;
    logic [3:0]  t_last_data;
    int fd_last = 0;
    int fd_prev = 0;

    el_scan_out dut (
        .pixClk    (pixClk),
        .nReset    (nReset),
        .enable    (enable),
        .rdAddr    (rdAddr),
        .rdEn      (rdEn),
        .rdData    (rdData),
        .elData    (elData),
        .elDataEn  (elDataEn),
        .elHsync   (elHsync),
        .elVsync   (elVsync),
        .frameDone (frameDone)
    );

    always #5 pixClk = ~pixClk;

    function automatic logic [7:0] ram_data(input logic [14:0] a);
        if (const_mode) return 8'h1F;
        return (a[7:0] ^ {1'b0, a[14:8]}) ^ 8'h5A;
    endfunction

    function automatic logic [3:0] grey(input logic [7:0] d, input int ph);
        return d[7:4] | (d[3:0] & {4{ph == 0}});
    endfunction

    // Stage-0 expectation for position k of a frame; zero outside the frame
    function automatic s0_t exp0(input int k);
        s0_t e;
        int line;
        int col;
        e = '0;
        if (k >= 0 && k < FRAME) begin
            line   = k / HT;
            col    = k % HT;
            e.de   = (line < VL) && (col < HB);
            e.addr = 15'(line * HB + col);
            e.hs   = (col >= HB + 2) && (col < HB + 2 + HSW);
            e.vs   = (line == 0);
            e.fd   = (k == FRAME - 1);
        end
        return e;
    endfunction

    // RAM model: data valid one clock after the read strobe
    always @(posedge pixClk) begin
        cyc <= cyc + 1;
        if (rdEn === 1'b1) rdData <= ram_data(rdAddr);
    end

    task automatic clear_tallies();
        t_en = 0; t_addr = 0; t_de = 0; t_hs = 0; t_vs = 0; t_fd = 0; t_data = 0;
        t_rd = 0; t_hs_cnt = 0; t_vs_cnt = 0; t_fd_cnt = 0;
        t_last = 15'h7FFF; t_first = 15'h7FFF; t_line1 = 15'h7FFF; t_last_data = 4'h0;
    endtask

    // Walk positions k_from..k_to (one negedge each) and tally deviations
    task automatic observe(input int k_from, input int k_to, input int ph);
        s0_t e0;
        s0_t eo;
        for (int k = k_from; k <= k_to; k++) begin
            @(negedge pixClk);
            e0 = exp0(k);
            eo = exp0(k - 2);
            if (k == 1) eo.fd = carry_fd;
            if (rdEn !== e0.de) t_en++;
            if (rdEn === 1'b1) begin
                t_rd++;
                t_last = rdAddr;
                if (k == 0)  t_first = rdAddr;
                if (k == HT) t_line1 = rdAddr;
                if (rdAddr !== e0.addr) t_addr++;
            end
            if (elDataEn !== eo.de) t_de++;
            if (elHsync !== eo.hs) t_hs++;
            if (elVsync !== eo.vs) t_vs++;
            if (frameDone !== eo.fd) t_fd++;
            if (eo.de) begin
                if (elData !== grey(ram_data(eo.addr), ph)) t_data++;
                t_last_data = elData;
            end
            if (elHsync === 1'b1) t_hs_cnt++;
            if (elVsync === 1'b1) t_vs_cnt++;
            if (frameDone === 1'b1) begin
                t_fd_cnt++;
                fd_prev = fd_last;
                fd_last = cyc;
            end
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        nReset = 1'b0;
        repeat (3) @(negedge pixClk);
        n_cmp++; if ({rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone} !== 24'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone});
        end
        nReset = 1'b1;
        @(negedge pixClk);
        n_cmp++; if (rdEn !== 1'b1) begin n_bad++; $display("FAIL reset_first_rden: got %b want 1", rdEn); end
        n_cmp++; if (rdAddr !== 15'd0) begin n_bad++; $display("FAIL reset_first_addr: got %0d want 0", rdAddr); end
        n_cmp++; if (elDataEn !== 1'b0) begin n_bad++; $display("FAIL reset_de_k0: got %b want 0", elDataEn); end
        @(negedge pixClk);
        n_cmp++; if (elDataEn !== 1'b0) begin n_bad++; $display("FAIL reset_de_k1: got %b want 0", elDataEn); end
        @(negedge pixClk);
        n_cmp++; if (elDataEn !== 1'b1) begin n_bad++; $display("FAIL reset_de_k2: got %b want 1", elDataEn); end
        n_cmp++; if (elVsync !== 1'b1) begin n_bad++; $display("FAIL reset_vs_k2: got %b want 1", elVsync); end
        n_cmp++; if (elData !== 4'hF) begin n_bad++; $display("FAIL reset_data_k2: got %h want f", elData); end
        #1 nReset = 1'b0;
        #1;
        n_cmp++; if ({rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone} !== 24'h0) begin
            n_bad++; $display("FAIL reset_async_clear: got %h want 0", {rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone});
        end
    endtask

    task automatic test_sweep_and_strobes();
        const_mode = 1'b0;
        carry_fd   = 1'b0;
        clear_tallies();
        @(negedge pixClk);
        nReset = 1'b1;
        observe(0, FRAME - 1, 0);
        n_cmp++; if (t_en !== 0)       begin n_bad++; $display("FAIL sweep_rden: %0d bad cycles want 0", t_en); end
        n_cmp++; if (t_addr !== 0)     begin n_bad++; $display("FAIL sweep_addr: %0d bad reads want 0", t_addr); end
        n_cmp++; if (t_rd !== 19200)   begin n_bad++; $display("FAIL sweep_read_count: got %0d want 19200", t_rd); end
        n_cmp++; if (t_first !== 15'd0)  begin n_bad++; $display("FAIL sweep_first: got %0d want 0", t_first); end
        n_cmp++; if (t_line1 !== 15'd80) begin n_bad++; $display("FAIL sweep_line1: got %0d want 80", t_line1); end
        n_cmp++; if (t_last !== 15'd19199) begin n_bad++; $display("FAIL sweep_last: got %0d want 19199", t_last); end
        n_cmp++; if (t_de !== 0)       begin n_bad++; $display("FAIL strobe_de: %0d bad cycles want 0", t_de); end
        n_cmp++; if (t_data !== 0)     begin n_bad++; $display("FAIL sweep_data: %0d bad pixels want 0", t_data); end
        n_cmp++; if (t_hs !== 0)       begin n_bad++; $display("FAIL strobe_hsync: %0d bad cycles want 0", t_hs); end
        n_cmp++; if (t_hs_cnt !== 976) begin n_bad++; $display("FAIL strobe_hsync_count: got %0d want 976", t_hs_cnt); end
        n_cmp++; if (t_vs !== 0)       begin n_bad++; $display("FAIL strobe_vsync: %0d bad cycles want 0", t_vs); end
        n_cmp++; if (t_vs_cnt !== 88)  begin n_bad++; $display("FAIL strobe_vsync_count: got %0d want 88", t_vs_cnt); end
        n_cmp++; if (t_fd_cnt !== 0)   begin n_bad++; $display("FAIL strobe_fd_early: got %0d want 0", t_fd_cnt); end
        carry_fd = 1'b1;
    endtask

    task automatic test_enable_drop();
        const_mode = 1'b1;
        clear_tallies();
        observe(0, 100 * HT, 1);
        enable = 1'b0;
        observe(100 * HT + 1, FRAME + 199, 1);
        n_cmp++; if (t_en !== 0)         begin n_bad++; $display("FAIL drop_rden: %0d bad cycles want 0", t_en); end
        n_cmp++; if (t_addr !== 0)       begin n_bad++; $display("FAIL drop_addr: %0d bad reads want 0", t_addr); end
        n_cmp++; if (t_rd !== 19200)     begin n_bad++; $display("FAIL drop_read_count: got %0d want 19200", t_rd); end
        n_cmp++; if (t_last !== 15'd19199) begin n_bad++; $display("FAIL drop_last: got %0d want 19199", t_last); end
        n_cmp++; if (t_fd !== 0)         begin n_bad++; $display("FAIL drop_fd: %0d bad cycles want 0", t_fd); end
        n_cmp++; if (t_fd_cnt !== 2)     begin n_bad++; $display("FAIL drop_fd_count: got %0d want 2", t_fd_cnt); end
        n_cmp++; if (fd_last - fd_prev !== FRAME) begin n_bad++; $display("FAIL frame_period: got %0d want %0d", fd_last - fd_prev, FRAME); end
        n_cmp++; if (t_de !== 0)         begin n_bad++; $display("FAIL drop_de: %0d bad cycles want 0", t_de); end
        n_cmp++; if (t_data !== 0)       begin n_bad++; $display("FAIL grey_phase1: %0d bad pixels want 0", t_data); end
        n_cmp++; if (t_last_data !== 4'h1) begin n_bad++; $display("FAIL grey_phase1_value: got %h want 1", t_last_data); end
        n_cmp++; if (rdEn !== 1'b0)      begin n_bad++; $display("FAIL drop_idle_rden: got %b want 0", rdEn); end
        carry_fd = 1'b0;
    endtask

    task automatic test_grey_levels();
        enable = 1'b1;
        clear_tallies();
        observe(0, FRAME - 1, 2);
        n_cmp++; if (t_first !== 15'd0)  begin n_bad++; $display("FAIL restart_first: got %0d want 0", t_first); end
        n_cmp++; if (t_en !== 0)         begin n_bad++; $display("FAIL restart_rden: %0d bad cycles want 0", t_en); end
        n_cmp++; if (t_addr !== 0)       begin n_bad++; $display("FAIL restart_addr: %0d bad reads want 0", t_addr); end
        n_cmp++; if (t_data !== 0)       begin n_bad++; $display("FAIL grey_phase2: %0d bad pixels want 0", t_data); end
        n_cmp++; if (t_last_data !== 4'h1) begin n_bad++; $display("FAIL grey_phase2_value: got %h want 1", t_last_data); end
        carry_fd = 1'b1;
    endtask

    task automatic test_reset_midline();
        clear_tallies();
        observe(0, 10 * HT + 40, 0);
        n_cmp++; if (t_data !== 0)       begin n_bad++; $display("FAIL grey_wrap: %0d bad pixels want 0", t_data); end
        n_cmp++; if (t_last_data !== 4'hF) begin n_bad++; $display("FAIL grey_wrap_value: got %h want f", t_last_data); end
        n_cmp++; if (t_fd_cnt !== 1)     begin n_bad++; $display("FAIL wrap_fd_count: got %0d want 1", t_fd_cnt); end
        n_cmp++; if (rdAddr !== 15'd840) begin n_bad++; $display("FAIL midline_addr: got %0d want 840", rdAddr); end
        #1 nReset = 1'b0;
        #1;
        n_cmp++; if ({rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone} !== 24'h0) begin
            n_bad++; $display("FAIL midline_async_clear: got %h want 0", {rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone});
        end
        repeat (2) @(negedge pixClk);
        n_cmp++; if ({rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone} !== 24'h0) begin
            n_bad++; $display("FAIL midline_held: got %h want 0", {rdAddr, rdEn, elData, elDataEn, elHsync, elVsync, frameDone});
        end
        @(negedge pixClk);
        nReset   = 1'b1;
        carry_fd = 1'b0;
        clear_tallies();
        observe(0, 2 * HT - 1, 0);
        n_cmp++; if (t_first !== 15'd0)  begin n_bad++; $display("FAIL midline_restart_first: got %0d want 0", t_first); end
        n_cmp++; if (t_en !== 0)         begin n_bad++; $display("FAIL midline_restart_rden: %0d bad cycles want 0", t_en); end
        n_cmp++; if (t_addr !== 0)       begin n_bad++; $display("FAIL midline_restart_addr: %0d bad reads want 0", t_addr); end
        n_cmp++; if (t_de !== 0)         begin n_bad++; $display("FAIL midline_restart_de: %0d bad cycles want 0", t_de); end
        n_cmp++; if (t_data !== 0)       begin n_bad++; $display("FAIL midline_restart_data: %0d bad pixels want 0", t_data); end
        n_cmp++; if (t_last_data !== 4'hF) begin n_bad++; $display("FAIL midline_restart_phase0: got %h want f", t_last_data); end
    endtask

    initial begin
        clear_tallies();
        test_reset();
        test_sweep_and_strobes();
        test_enable_drop();
        test_grey_levels();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
